// File: rtl/awg_pkg.sv
// Shared encodings and widths for the AWG front-panel control slice.
package awg_pkg;

   localparam int FREQ_W  = 12;
   localparam int AMP_W   = 3;
   localparam int PHASE_W = 8;

   localparam logic [AMP_W-1:0] AMP_RST = 3'd7;

   typedef enum logic [1:0] {
      MODE_FREQ  = 2'd0,
      MODE_AMP   = 2'd1,
      MODE_PHASE = 2'd2
   } mode_e;

endpackage

// File: rtl/key_debounce.sv
// Raw active-low button -> 2-FF sync -> stability counter -> debounced level
// plus a one-cycle press pulse on each accepted 1->0 transition.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync  <= 2'b11;
         cnt   <= '0;
         level <= 1'b1;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], key_n};
         press <= 1'b0;
         if (sync[1] != level) begin
            // The flip happens on the DEBOUNCE_CYCLES-th consecutive differing sample.
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               level <= sync[1];
               cnt   <= '0;
               press <= ~sync[1];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/awg_param_ctrl.sv
// Front-panel control: four debounced keys, FREQ/AMP/PHASE edit FSM, run toggle.
// Optional hold-to-repeat on up/down keys under AWG_PARAM_CTRL_AUTO_REPEAT_EN.
module awg_param_ctrl
   import awg_pkg::*;
#(
   parameter int                   DEBOUNCE_CYCLES = 500000,
   parameter logic [FREQ_W-1:0]    FREQ_MAX        = 12'd4095,
   parameter logic [FREQ_W-1:0]    FREQ_MIN        = 12'd1,
`ifdef AWG_PARAM_CTRL_AUTO_REPEAT_EN
   parameter int                   REPEAT_DELAY    = 1000000,
   parameter int                   REPEAT_PERIOD   = 200000,
`endif
   parameter logic [PHASE_W-1:0]   PHASE_STEP      = 8'd8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_mode_n,
   input  logic               key_up_n,
   input  logic               key_down_n,
   input  logic               key_run_n,
   output logic               en,
   output logic [FREQ_W-1:0]  state_freq,
   output logic [AMP_W-1:0]   state_amp,
   output logic [PHASE_W-1:0] state_phase,
   output logic [1:0]         mode
);

   localparam int K_MODE = 0;
   localparam int K_UP   = 1;
   localparam int K_DN   = 2;
   localparam int K_RUN  = 3;

   logic [3:0] key_raw, level, press;
   logic       step_up, step_dn;
   mode_e      mode_q, mode_d;

   assign key_raw = {key_run_n, key_down_n, key_up_n, key_mode_n};

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
         .clk   (clk),
         .rst_n (rst_n),
         .key_n (key_raw[k]),
         .level (level[k]),
         .press (press[k])
      );
   end

`ifdef AWG_PARAM_CTRL_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rpt_cnt;
   logic          rpt_periodic, held_up, held_dn, rpt_fire;

   assign held_up  = ~level[K_UP] &  level[K_DN];
   assign held_dn  =  level[K_UP] & ~level[K_DN];
   assign rpt_fire = (held_up | held_dn) & ~press[K_MODE] &
                     (rpt_cnt == (rpt_periodic ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));

   // Counter sits at 0 on the press cycle, so the first repeat lands REPEAT_DELAY later.
   always_ff @(posedge clk) begin
      if (!rst_n || !(held_up || held_dn) || press[K_MODE]) begin
         rpt_cnt      <= '0;
         rpt_periodic <= 1'b0;
      end else if (rpt_fire) begin
         rpt_cnt      <= RW'(1);
         rpt_periodic <= 1'b1;
      end else begin
         rpt_cnt <= rpt_cnt + 1'b1;
      end
   end

   assign step_up = press[K_UP] | (rpt_fire & held_up);
   assign step_dn = press[K_DN] | (rpt_fire & held_dn);
`else
   assign step_up = press[K_UP];
   assign step_dn = press[K_DN];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) mode_q <= MODE_FREQ;
      else        mode_q <= mode_d;
   end

   always_comb begin
      mode_d = mode_q;
      if (press[K_MODE]) begin
         case (mode_q)
            MODE_FREQ: mode_d = MODE_AMP;
            MODE_AMP:  mode_d = MODE_PHASE;
            default:   mode_d = MODE_FREQ;
         endcase
      end
   end

   assign mode = mode_q;

   // A mode step suppresses any up/down edit in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en          <= 1'b0;
         state_freq  <= FREQ_MIN;
         state_amp   <= AMP_RST;
         state_phase <= '0;
      end else begin
         if (press[K_RUN]) en <= ~en;
         if (!press[K_MODE] && (step_up ^ step_dn)) begin
            case (mode_q)
               MODE_FREQ: begin
                  if (step_up) begin
                     if (state_freq < FREQ_MAX) state_freq <= state_freq + 1'b1;
                  end else if (state_freq > FREQ_MIN) begin
                     state_freq <= state_freq - 1'b1;
                  end
               end
               MODE_AMP: begin
                  if (step_up) begin
                     if (state_amp != '1) state_amp <= state_amp + 1'b1;
                  end else if (state_amp != '0) begin
                     state_amp <= state_amp - 1'b1;
                  end
               end
               MODE_PHASE: begin
                  if (step_up) state_phase <= state_phase + PHASE_STEP;
                  else         state_phase <= state_phase - PHASE_STEP;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
